// File: rtl/rcc_bdcr_pkg.sv
// Shared definitions for the BDCR bus-side write controller: field layout,
// lane-to-field mapping and FSM encoding.
package rcc_bdcr_pkg;

  // BDCR field positions
  localparam int unsigned BdrstBit    = 16;
  localparam int unsigned RtcenBit    = 15;
  localparam int unsigned RtcselLsb   = 8;
  localparam int unsigned RtcselW     = 2;
  localparam int unsigned LsecssdBit  = 6;
  localparam int unsigned LsecssonBit = 5;
  localparam int unsigned LsedrvLsb   = 3;
  localparam int unsigned LsedrvW     = 2;
  localparam int unsigned LsebypBit   = 2;
  localparam int unsigned LserdyBit   = 1;
  localparam int unsigned LseonBit    = 0;

  // Byte lanes: lane 0 carries the LSE controls, lane 1 the RTC controls,
  // lane 2 the backup-domain software reset.
  localparam int unsigned NumLanes  = 3;
  localparam int unsigned LaneLse   = 0;
  localparam int unsigned LaneRtc   = 1;
  localparam int unsigned LaneBdrst = 2;

  // Number of backup-domain bits synchronized back for read-back
  localparam int unsigned RbW = 11;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold
  } bdcr_state_e;

  typedef struct packed {
    logic       bdrst;
    logic       rtcen;
    logic [1:0] rtcsel;
    logic       lsecsson;
    logic [1:0] lsedrv;
    logic       lsebyp;
    logic       lseon;
  } bdcr_nxt_t;

  // Replace only the fields belonging to enabled lanes.
  function automatic bdcr_nxt_t merge_lanes(bdcr_nxt_t cur, logic [31:0] data,
                                            logic [NumLanes-1:0] lane);
    bdcr_nxt_t res;
    res = cur;
    if (lane[LaneLse]) begin
      res.lsecsson = data[LsecssonBit];
      res.lsedrv   = data[LsedrvLsb +: LsedrvW];
      res.lsebyp   = data[LsebypBit];
      res.lseon    = data[LseonBit];
    end
    if (lane[LaneRtc]) begin
      res.rtcen  = data[RtcenBit];
      res.rtcsel = data[RtcselLsb +: RtcselW];
    end
    if (lane[LaneBdrst]) begin
      res.bdrst = data[BdrstBit];
    end
    return res;
  endfunction

endpackage

// File: rtl/rcc_bdcr_sync.sv
// Multi-stage flop synchronizer, per-bit, async active-low reset to zero.
module rcc_bdcr_sync #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Stages];
  logic [Width-1:0] stage_d [Stages];

  // Shift the chain by one stage per clock
  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < int'(Stages); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Stages); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Stages); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/rcc_bdcr_wr_ctrl.sv
// Bus-side BDCR writer: turns a one-cycle decode write into registered,
// glitch-free byte strobes with setup/hold-framed data, and synchronizes the
// backup-domain state back into the bus clock.
module rcc_bdcr_wr_ctrl
  import rcc_bdcr_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbp,
  input  logic        bdcr_wr_req,
  input  logic [31:0] bdcr_wr_data,
  input  logic [3:0]  bdcr_wr_strb,
  output logic        bdcr_wr_busy,
  output logic        bdcr_wr_err,
  output logic        rcc_bdcr_byte0_wren,
  output logic        rcc_bdcr_byte1_wren,
  output logic        rcc_bdcr_byte2_wren,
  output logic        nxt_rcc_bdcr_bdrst,
  output logic        nxt_rcc_bdcr_rtcen,
  output logic [1:0]  nxt_rcc_bdcr_rtcsel,
  output logic        nxt_rcc_bdcr_lsecsson,
  output logic [1:0]  nxt_rcc_bdcr_lsedrv,
  output logic        nxt_rcc_bdcr_lsebyp,
  output logic        nxt_rcc_bdcr_lseon,
  input  logic        cur_rcc_bdcr_bdrst,
  input  logic        cur_rcc_bdcr_rtcen,
  input  logic [1:0]  cur_rcc_bdcr_rtcsel,
  input  logic        cur_rcc_bdcr_lsecssd,
  input  logic        cur_rcc_bdcr_lsecsson,
  input  logic [1:0]  cur_rcc_bdcr_lsedrv,
  input  logic        cur_rcc_bdcr_lsebyp,
  input  logic        cur_rcc_bdcr_lseon,
  input  logic        cur_rcc_bdcr_lserdy,
  input  logic        lsecss_fail,
  output logic [31:0] bdcr_rdata,
  output logic        lsecss_fail_sync
);

  localparam int unsigned MaxCyc01 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MaxCyc   = (MaxCyc01 > HOLD_CYC) ? MaxCyc01 : HOLD_CYC;
  localparam int unsigned CntW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

  bdcr_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumLanes-1:0] lane_q, lane_d;
  logic [NumLanes-1:0] wren_q, wren_d;
  bdcr_nxt_t           nxt_q, nxt_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                cnt_zero;

  // Data bits without a writable field, and the unused fourth byte enable
  logic unused_wr;
  assign unused_wr = ^{bdcr_wr_strb[3], bdcr_wr_data[31:17], bdcr_wr_data[14:10],
                       bdcr_wr_data[7:6], bdcr_wr_data[1]};

  assign cnt_zero = (cnt_q == '0);

  // Sequencer next-state: accept, frame setup/pulse/hold, flag bad requests
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    nxt_d   = nxt_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bdcr_wr_req) begin
          if (!dbp) begin
            err_d = 1'b1;
          end else if (|bdcr_wr_strb[NumLanes-1:0]) begin
            lane_d  = bdcr_wr_strb[NumLanes-1:0];
            nxt_d   = merge_lanes(nxt_q, bdcr_wr_data, bdcr_wr_strb[NumLanes-1:0]);
            state_d = StSetup;
            cnt_d   = SetupLd;
          end
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A request during a sequence is dropped and flagged
    if (state_q != StIdle && bdcr_wr_req) begin
      err_d = 1'b1;
    end
  end

  // Strobes and busy are decoded from the next state so the flops drive them cleanly
  always_comb begin
    wren_d = (state_d == StPulse) ? lane_q : '0;
    busy_d = (state_d != StIdle);
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lane_q  <= '0;
      wren_q  <= '0;
      nxt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      wren_q  <= wren_d;
      nxt_q   <= nxt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bdcr_wr_busy          = busy_q;
  assign bdcr_wr_err           = err_q;
  assign rcc_bdcr_byte0_wren   = wren_q[LaneLse];
  assign rcc_bdcr_byte1_wren   = wren_q[LaneRtc];
  assign rcc_bdcr_byte2_wren   = wren_q[LaneBdrst];
  assign nxt_rcc_bdcr_bdrst    = nxt_q.bdrst;
  assign nxt_rcc_bdcr_rtcen    = nxt_q.rtcen;
  assign nxt_rcc_bdcr_rtcsel   = nxt_q.rtcsel;
  assign nxt_rcc_bdcr_lsecsson = nxt_q.lsecsson;
  assign nxt_rcc_bdcr_lsedrv   = nxt_q.lsedrv;
  assign nxt_rcc_bdcr_lsebyp   = nxt_q.lsebyp;
  assign nxt_rcc_bdcr_lseon    = nxt_q.lseon;

  // Read-back path
  logic [RbW-1:0] rb_async, rb_sync;

  assign rb_async = {cur_rcc_bdcr_bdrst, cur_rcc_bdcr_rtcen, cur_rcc_bdcr_rtcsel,
                     cur_rcc_bdcr_lsecssd, cur_rcc_bdcr_lsecsson, cur_rcc_bdcr_lsedrv,
                     cur_rcc_bdcr_lsebyp, cur_rcc_bdcr_lserdy, cur_rcc_bdcr_lseon};

  rcc_bdcr_sync #(
    .Stages (SYNC_STAGES),
    .Width  (RbW)
  ) u_rb_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rb_async),
    .q_o    (rb_sync)
  );

  rcc_bdcr_sync #(
    .Stages (SYNC_STAGES),
    .Width  (1)
  ) u_css_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (lsecss_fail),
    .q_o    (lsecss_fail_sync)
  );

  // Place synchronized bits at their BDCR positions
  always_comb begin
    bdcr_rdata                              = '0;
    bdcr_rdata[LseonBit]                    = rb_sync[0];
    bdcr_rdata[LserdyBit]                   = rb_sync[1];
    bdcr_rdata[LsebypBit]                   = rb_sync[2];
    bdcr_rdata[LsedrvLsb +: LsedrvW]        = rb_sync[4:3];
    bdcr_rdata[LsecssonBit]                 = rb_sync[5];
    bdcr_rdata[LsecssdBit]                  = rb_sync[6];
    bdcr_rdata[RtcselLsb +: RtcselW]        = rb_sync[8:7];
    bdcr_rdata[RtcenBit]                    = rb_sync[9];
    bdcr_rdata[BdrstBit]                    = rb_sync[10];
  end

endmodule

// File: tb/tb_rcc_bdcr_wr_ctrl.sv
// Directed bench for the BDCR write controller (default timing parameters).
module tb_rcc_bdcr_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbp;
  logic        bdcr_wr_req;
  logic [31:0] bdcr_wr_data;
  logic [3:0]  bdcr_wr_strb;
  logic        bdcr_wr_busy;
  logic        bdcr_wr_err;
  logic        b0_wren, b1_wren, b2_wren;
  logic        nxt_bdrst, nxt_rtcen, nxt_lsecsson, nxt_lsebyp, nxt_lseon;
  logic [1:0]  nxt_rtcsel, nxt_lsedrv;
  logic        cur_bdrst, cur_rtcen, cur_lsecssd, cur_lsecsson, cur_lsebyp, cur_lseon;
  logic        cur_lserdy;
  logic [1:0]  cur_rtcsel, cur_lsedrv;
  logic        lsecss_fail;
  logic [31:0] bdcr_rdata;
  logic        lsecss_fail_sync;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rcc_bdcr_wr_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .dbp                   (dbp),
    .bdcr_wr_req           (bdcr_wr_req),
    .bdcr_wr_data          (bdcr_wr_data),
    .bdcr_wr_strb          (bdcr_wr_strb),
    .bdcr_wr_busy          (bdcr_wr_busy),
    .bdcr_wr_err           (bdcr_wr_err),
    .rcc_bdcr_byte0_wren   (b0_wren),
    .rcc_bdcr_byte1_wren   (b1_wren),
    .rcc_bdcr_byte2_wren   (b2_wren),
    .nxt_rcc_bdcr_bdrst    (nxt_bdrst),
    .nxt_rcc_bdcr_rtcen    (nxt_rtcen),
    .nxt_rcc_bdcr_rtcsel   (nxt_rtcsel),
    .nxt_rcc_bdcr_lsecsson (nxt_lsecsson),
    .nxt_rcc_bdcr_lsedrv   (nxt_lsedrv),
    .nxt_rcc_bdcr_lsebyp   (nxt_lsebyp),
    .nxt_rcc_bdcr_lseon    (nxt_lseon),
    .cur_rcc_bdcr_bdrst    (cur_bdrst),
    .cur_rcc_bdcr_rtcen    (cur_rtcen),
    .cur_rcc_bdcr_rtcsel   (cur_rtcsel),
    .cur_rcc_bdcr_lsecssd  (cur_lsecssd),
    .cur_rcc_bdcr_lsecsson (cur_lsecsson),
    .cur_rcc_bdcr_lsedrv   (cur_lsedrv),
    .cur_rcc_bdcr_lsebyp   (cur_lsebyp),
    .cur_rcc_bdcr_lseon    (cur_lseon),
    .cur_rcc_bdcr_lserdy   (cur_lserdy),
    .lsecss_fail           (lsecss_fail),
    .bdcr_rdata            (bdcr_rdata),
    .lsecss_fail_sync      (lsecss_fail_sync)
  );

  // {bdrst, rtcen, rtcsel[1:0], lsecsson, lsedrv[1:0], lsebyp, lseon}
  logic [8:0] nxt_all;
  logic [2:0] wren_all;
  assign nxt_all  = {nxt_bdrst, nxt_rtcen, nxt_rtcsel, nxt_lsecsson, nxt_lsedrv,
                     nxt_lsebyp, nxt_lseon};
  assign wren_all = {b2_wren, b1_wren, b0_wren};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request so that the next rising edge is cycle 0; returns in cycle 1.
  task automatic issue(input logic [3:0] strb, input logic [31:0] data);
    bdcr_wr_req  = 1'b1;
    bdcr_wr_strb = strb;
    bdcr_wr_data = data;
    step();
    bdcr_wr_req  = 1'b0;
    bdcr_wr_strb = 4'b0000;
    bdcr_wr_data = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    dbp = 1'b1;
    bdcr_wr_req = 1'b0;
    bdcr_wr_data = '0;
    bdcr_wr_strb = '0;
    {cur_bdrst, cur_rtcen, cur_lsecssd, cur_lsecsson, cur_lsebyp, cur_lseon} = '0;
    cur_lserdy = 1'b0;
    cur_rtcsel = 2'b00;
    cur_lsedrv = 2'b00;
    lsecss_fail = 1'b0;

    // Reset state
    step();
    step();
    check("rst_wren", wren_all, 3'b000);
    check("rst_nxt", nxt_all, 9'h000);
    check("rst_busy", bdcr_wr_busy, 1'b0);
    check("rst_err", bdcr_wr_err, 1'b0);
    check("rst_rdata", bdcr_rdata, 32'h0);
    check("rst_css", lsecss_fail_sync, 1'b0);
    rst_n = 1'b1;
    step();

    // Full write: strobes high cycles 3-4, busy low at cycle 7
    issue(4'b0111, 32'h0001_8119);
    check("full_nxt_c1", nxt_all, 9'b1_1_01_0_11_0_1);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("full_wren_c%0d", c), wren_all, (c == 3 || c == 4) ? 3'b111 : 3'b000);
      check($sformatf("full_busy_c%0d", c), bdcr_wr_busy, (c < 7) ? 1'b1 : 1'b0);
      check($sformatf("full_err_c%0d", c), bdcr_wr_err, 1'b0);
      if (c < 7) step();
    end
    check("full_nxt_c7", nxt_all, 9'b1_1_01_0_11_0_1);

    // Lane masking: only lane 0 updates and strobes
    issue(4'b0001, 32'h0000_0004);
    check("mask_nxt_c1", nxt_all, 9'b1_1_01_0_00_1_0);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("mask_wren_c%0d", c), wren_all, (c == 3 || c == 4) ? 3'b001 : 3'b000);
      check($sformatf("mask_busy_c%0d", c), bdcr_wr_busy, (c < 7) ? 1'b1 : 1'b0);
      if (c < 7) step();
    end

    // Protection: dbp=0 gives a one-cycle error and nothing else
    dbp = 1'b0;
    issue(4'b0111, 32'h0001_8119);
    check("prot_err_c1", bdcr_wr_err, 1'b1);
    check("prot_busy_c1", bdcr_wr_busy, 1'b0);
    check("prot_nxt_c1", nxt_all, 9'b1_1_01_0_00_1_0);
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("prot_err_c%0d", c), bdcr_wr_err, 1'b0);
      check($sformatf("prot_wren_c%0d", c), wren_all, 3'b000);
      check($sformatf("prot_busy_c%0d", c), bdcr_wr_busy, 1'b0);
    end
    dbp = 1'b1;

    // Empty byte enables are ignored silently
    issue(4'b1000, 32'hFFFF_FFFF);
    check("empty_err", bdcr_wr_err, 1'b0);
    check("empty_busy", bdcr_wr_busy, 1'b0);
    check("empty_nxt", nxt_all, 9'b1_1_01_0_00_1_0);
    step();

    // Overlap: request at cycle 4 is dropped with an error at cycle 5
    issue(4'b0111, 32'h0001_8119);
    step();
    step();
    check("ovl_wren_c3", wren_all, 3'b111);
    step();
    check("ovl_wren_c4", wren_all, 3'b111);
    issue(4'b0111, 32'h0000_0000);
    check("ovl_err_c5", bdcr_wr_err, 1'b1);
    check("ovl_wren_c5", wren_all, 3'b000);
    check("ovl_busy_c5", bdcr_wr_busy, 1'b1);
    check("ovl_nxt_c5", nxt_all, 9'b1_1_01_0_11_0_1);
    step();
    check("ovl_err_c6", bdcr_wr_err, 1'b0);
    check("ovl_busy_c6", bdcr_wr_busy, 1'b1);
    step();
    check("ovl_busy_c7", bdcr_wr_busy, 1'b0);
    check("ovl_nxt_c7", nxt_all, 9'b1_1_01_0_11_0_1);
    step();
    check("ovl_wren_c8", wren_all, 3'b000);

    // Reset mid-PULSE clears everything at once
    issue(4'b0111, 32'h0001_8119);
    step();
    step();
    check("rstp_wren_c3", wren_all, 3'b111);
    rst_n = 1'b0;
    #1;
    check("rstp_wren", wren_all, 3'b000);
    check("rstp_busy", bdcr_wr_busy, 1'b0);
    check("rstp_nxt", nxt_all, 9'h000);
    #1;
    rst_n = 1'b1;
    step();

    // Write after reset completes normally
    issue(4'b0010, 32'h0000_0200);
    check("post_nxt_c1", nxt_all, 9'b0_0_10_0_00_0_0);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("post_wren_c%0d", c), wren_all, (c == 3 || c == 4) ? 3'b010 : 3'b000);
      check($sformatf("post_busy_c%0d", c), bdcr_wr_busy, (c < 7) ? 1'b1 : 1'b0);
      if (c < 7) step();
    end

    // Read-back: exactly two edges of latency
    cur_rtcsel  = 2'b10;
    cur_lserdy  = 1'b1;
    lsecss_fail = 1'b1;
    #1;
    check("rb_rdata_e0", bdcr_rdata, 32'h0);
    step();
    check("rb_rdata_e1", bdcr_rdata, 32'h0);
    check("rb_css_e1", lsecss_fail_sync, 1'b0);
    step();
    check("rb_rdata_e2", bdcr_rdata, 32'h0000_0202);
    check("rb_css_e2", lsecss_fail_sync, 1'b1);

    // Read-back of every field set
    {cur_bdrst, cur_rtcen, cur_lsecssd, cur_lsecsson, cur_lsebyp, cur_lseon} = '1;
    cur_rtcsel  = 2'b11;
    cur_lsedrv  = 2'b11;
    lsecss_fail = 1'b0;
    step();
    step();
    check("rb_all_rdata", bdcr_rdata, 32'h0001_837F);
    check("rb_all_css", lsecss_fail_sync, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
